// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: byte buffering between the CPU UART register decode and the
// serial transmitter/receiver pair. A TX FIFO feeds the transmitter through a
// start/busy handshake. An RX FIFO captures receiver strobes and presents a
// show-ahead head byte to the CPU.
// Optional feature: define UART_OVERRUN_FLAG_EN to add the sticky rx_overrun output.
module uart_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       txd_start,
    output logic [7:0] txd_data,
    input  logic       txd_busy,
    input  logic       rxd_data_ready,
    input  logic [7:0] rxd_data
`ifdef UART_OVERRUN_FLAG_EN
    ,
    output logic       rx_overrun
`endif
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } txState_t;

    txState_t        state, stateNext;

    logic [7:0]      txMem [DEPTH];
    logic [AW-1:0]   txWrPtr, txRdPtr;
    logic [CW-1:0]   txCount, txCountNext;
    logic            txPush, txPop;

    logic [7:0]      rxMem [DEPTH];
    logic [AW-1:0]   rxWrPtr, rxRdPtr, rxRdPtrNext;
    logic [CW-1:0]   rxCount, rxCountNext;
    logic            rxPush, rxPop;

    // TX handshake: pop one byte when idle and the transmitter is free
    always_comb begin
        stateNext = state;
        txPop     = 1'b0;
        case (state)
            IDLE: begin
                if (txCount != '0 && !txd_busy) begin
                    txPop     = 1'b1;
                    stateNext = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (txd_busy)  stateNext = WAIT_DONE;
            WAIT_DONE: if (!txd_busy) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // TX occupancy; a write into a full FIFO is dropped even alongside a pop
    always_comb begin
        txPush      = wr_en && !tx_full;
        txCountNext = txCount;
        case ({txPush, txPop})
            2'b10:   txCountNext = txCount + CW'(1);
            2'b01:   txCountNext = txCount - CW'(1);
            default: txCountNext = txCount;
        endcase
    end

    // TX state, pointers, flags and transmitter outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            txWrPtr   <= '0;
            txRdPtr   <= '0;
            txCount   <= '0;
            tx_full   <= 1'b0;
            tx_empty  <= 1'b1;
            txd_start <= 1'b0;
            txd_data  <= 8'h00;
        end else begin
            state     <= stateNext;
            txCount   <= txCountNext;
            tx_full   <= (txCountNext == CW'(DEPTH));
            tx_empty  <= (txCountNext == '0) && (stateNext == IDLE) && !txd_busy;
            txd_start <= txPop;
            if (txPush) txWrPtr <= txWrPtr + AW'(1);
            if (txPop) begin
                txRdPtr  <= txRdPtr + AW'(1);
                txd_data <= txMem[txRdPtr];
            end
        end
    end

    // TX storage (not reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (txPush) txMem[txWrPtr] <= wr_data;
    end

    // RX push/pop decode; full is judged before any same-cycle pop
    always_comb begin
        rxPush      = rxd_data_ready && !rx_full;
        rxPop       = rd_en && !rx_empty;
        rxRdPtrNext = rxPop ? rxRdPtr + AW'(1) : rxRdPtr;
        case ({rxPush, rxPop})
            2'b10:   rxCountNext = rxCount + CW'(1);
            2'b01:   rxCountNext = rxCount - CW'(1);
            default: rxCountNext = rxCount;
        endcase
    end

    // RX pointers, flags and the registered show-ahead head byte
    always_ff @(posedge clk) begin
        if (rst) begin
            rxWrPtr  <= '0;
            rxRdPtr  <= '0;
            rxCount  <= '0;
            rx_full  <= 1'b0;
            rx_empty <= 1'b1;
            rd_data  <= 8'h00;
        end else begin
            rxCount  <= rxCountNext;
            rxRdPtr  <= rxRdPtrNext;
            rx_full  <= (rxCountNext == CW'(DEPTH));
            rx_empty <= (rxCountNext == '0);
            if (rxPush) rxWrPtr <= rxWrPtr + AW'(1);
            // bypass when the byte being written becomes the new head
            if (rxPop || (rxPush && rx_empty)) begin
                rd_data <= (rxPush && rxWrPtr == rxRdPtrNext) ? rxd_data : rxMem[rxRdPtrNext];
            end
        end
    end

    // RX storage
    always_ff @(posedge clk) begin
        if (rxPush) rxMem[rxWrPtr] <= rxd_data;
    end

`ifdef UART_OVERRUN_FLAG_EN
    // Sticky overrun: set on a dropped strobe, cleared by a read while empty; set wins
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun <= 1'b0;
        end else if (rxd_data_ready && rx_full) begin
            rx_overrun <= 1'b1;
        end else if (rd_en && rx_empty) begin
            rx_overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge (DEPTH_LOG2=2): a transmitter model
// with a byte scoreboard for the TX path, and a per-cycle vector table for RX.
module tb_uart_fifo_bridge;

    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int          DEPTH      = 4;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en, txd_busy, rxd_data_ready;
    logic [7:0] wr_data, rxd_data, rd_data, txd_data;
    logic       tx_full, tx_empty, rx_empty, rx_full, txd_start;
`ifdef UART_OVERRUN_FLAG_EN
    logic       rx_overrun;
`endif

    uart_fifo_bridge #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .tx_full        (tx_full),
        .tx_empty       (tx_empty),
        .rx_empty       (rx_empty),
        .rx_full        (rx_full),
        .txd_start      (txd_start),
        .txd_data       (txd_data),
        .txd_busy       (txd_busy),
        .rxd_data_ready (rxd_data_ready),
        .rxd_data       (rxd_data)
`ifdef UART_OVERRUN_FLAG_EN
        ,
        .rx_overrun     (rx_overrun)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         startCount = 0;
    int         lastStartCyc = -100;
    int         busyLeft = 0;
    bit         pendStart = 1'b0;
    bit         busyHold = 1'b0;
    logic [7:0] txQ[$];

    typedef struct {
        logic       stb;
        logic [7:0] din;
        logic       rd;
        logic       expEmpty;
        logic       expFull;
        logic       chkData;
        logic [7:0] expData;
        logic       expOvr;
    } rxVec_t;

    rxVec_t vec[20];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitStarts(input string name, input int n, input int budget);
        int k = 0;
        while (startCount < n && k < budget) begin
            step();
            k++;
        end
        chkInt(name, startCount, n);
    endtask

    task automatic writeByte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        txQ.push_back(b);
        step();
        wr_en   = 1'b0;
    endtask

    // Transmitter model: busy rises the cycle after start and stays high 20 cycles
    initial begin
        txd_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (txd_start) begin
                startCount++;
                chk1("start_while_busy", txd_busy, 1'b0);
                chk1("start_gap_ge3", (cyc - lastStartCyc) >= 3, 1'b1);
                lastStartCyc = cyc;
                if (txQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start actual=%02h required=none", txd_data);
                end else begin
                    chk8("txd_data", txd_data, txQ.pop_front());
                end
            end
            if (busyLeft > 0) busyLeft--;
            if (pendStart) begin
                busyLeft  = 20;
                pendStart = 1'b0;
            end
            if (txd_start) pendStart = 1'b1;
            txd_busy = busyHold || (busyLeft > 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int mcount;
        int k;

        // stb din rd | empty full chk data ovr
        vec[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vec[1]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
        vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vec[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
        vec[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
        vec[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
        vec[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
        vec[9]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1};
        vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1};
        vec[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1};
        vec[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1};
        vec[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vec[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vec[15] = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 8'h06, 1'b0};
        vec[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vec[17] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0};
        vec[18] = '{1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0};
        vec[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        rxd_data_ready = 1'b0; rxd_data = 8'h00;

        // Reset state, then 10 idle cycles
        step(); step();
        chk1("rst_tx_empty", tx_empty, 1'b1);
        chk1("rst_rx_empty", rx_empty, 1'b1);
        chk1("rst_tx_full", tx_full, 1'b0);
        chk1("rst_rx_full", rx_full, 1'b0);
        chk1("rst_txd_start", txd_start, 1'b0);
        chk8("rst_txd_data", txd_data, 8'h00);
        chk8("rst_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk1("idle_tx_empty", tx_empty, 1'b1);
        chk1("idle_rx_empty", rx_empty, 1'b1);
        chk8("idle_rd_data", rd_data, 8'h00);
        chkInt("idle_no_start", startCount, 0);

        // Two back-to-back writes, each gated by the busy handshake
        writeByte(8'h41);
        writeByte(8'h42);
        step();
        chk1("tx2_not_empty", tx_empty, 1'b0);
        waitStarts("tx2_starts", 2, 100);
        for (int i = 0; i < 30; i++) step();
        chkInt("tx2_exact_starts", startCount, 2);
        chkInt("tx2_queue_drained", txQ.size(), 0);
        chk1("tx2_empty_after", tx_empty, 1'b1);

        // Overfill the TX FIFO while the transmitter is held busy
        base = startCount;
        mcount = 0;
        busyHold = 1'b1;
        step(); step();
        for (int i = 1; i <= 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            if (mcount < DEPTH) begin
                txQ.push_back(8'(i));
                mcount++;
            end
            step();
            chk1($sformatf("tx_full_wr%0d", i), tx_full, mcount == DEPTH);
        end
        wr_en = 1'b0;
        step();
        chk1("tx_hold_not_empty", tx_empty, 1'b0);
        chkInt("tx_hold_no_start", startCount, base);
        busyHold = 1'b0;
        waitStarts("txfull_starts", base + 4, 200);
        for (int i = 0; i < 30; i++) step();
        chkInt("txfull_exact_starts", startCount, base + 4);
        chkInt("txfull_queue_drained", txQ.size(), 0);
        chk1("txfull_empty_after", tx_empty, 1'b1);
        chk1("txfull_full_after", tx_full, 1'b0);

        // RX vector table, one row per clock
        for (int i = 0; i < 20; i++) begin
            rxd_data_ready = vec[i].stb;
            rxd_data       = vec[i].din;
            rd_en          = vec[i].rd;
            step();
            rxd_data_ready = 1'b0;
            rd_en          = 1'b0;
            chk1($sformatf("rx%0d_empty", i), rx_empty, vec[i].expEmpty);
            chk1($sformatf("rx%0d_full", i), rx_full, vec[i].expFull);
            if (vec[i].chkData) chk8($sformatf("rx%0d_rd_data", i), rd_data, vec[i].expData);
`ifdef UART_OVERRUN_FLAG_EN
            chk1($sformatf("rx%0d_overrun", i), rx_overrun, vec[i].expOvr);
`endif
        end

        // Reset while waiting for the transmitter with two bytes queued
        base = startCount;
        writeByte(8'hC1);
        writeByte(8'hC2);
        writeByte(8'hC3);
        waitStarts("rstmid_first_start", base + 1, 20);
        k = 0;
        while (!txd_busy && k < 20) begin
            step();
            k++;
        end
        chk1("rstmid_busy_seen", txd_busy, 1'b1);
        step(); step(); step();
        chk1("rstmid_not_empty", tx_empty, 1'b0);
        rst = 1'b1;
        step();
        void'(txQ.pop_front());
        void'(txQ.pop_front());
        chk1("rstmid_tx_empty", tx_empty, 1'b1);
        chk1("rstmid_tx_full", tx_full, 1'b0);
        chk1("rstmid_txd_start", txd_start, 1'b0);
        chk8("rstmid_txd_data", txd_data, 8'h00);
        chk1("rstmid_busy_still", txd_busy, 1'b1);
        rst = 1'b0;
        writeByte(8'hD7);
        chkInt("rstmid_no_start_yet", startCount, base + 1);
        waitStarts("rstmid_new_start", base + 2, 100);
        for (int i = 0; i < 30; i++) step();
        chkInt("rstmid_exact_starts", startCount, base + 2);
        chkInt("rstmid_queue_drained", txQ.size(), 0);
        chk1("rstmid_empty_after", tx_empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
